adc_scan_sched: RTL
===================

# adc_scan_sched

Channel scheduler for the 8-channel serial ADC interface. Decides which channel each conversion frame addresses, gives one-shot host requests priority over a round-robin background scan, and stores 12-bit results per channel. The ADC returns the result for the channel addressed in the *previous* frame, so the block tracks a one-frame channel tag pipeline. It sits between system control logic and the ADC serial engine: it drives that engine's start and channel inputs and consumes its done/data outputs.

## Interface
- GAP_CYCLES, 2: idle iCLK cycles between frames; 0 means back-to-back frames.
- TIMEOUT_CYCLES, 64: WAIT cycles allowed without iDONE; used only with the macro.
- iCLK  in  1  system clock; all logic on its rising edge.
- iRST  in  1  reset, asynchronous, active-low.
- iEN  in  1  scheduler enable.
- iMASK  in  8  background scan channel mask.
- iREQ  in  1  one-shot conversion request; held until oREQ_ACK.
- iREQ_CH  in  3  requested channel.
- oREQ_ACK  out  1  1-cycle pulse: request issued.
- oREQ_DONE  out  1  1-cycle pulse: requested channel's result written.
- oGO  out  1  1-cycle frame start to the serial engine.
- oCH  out  3  channel address for the frame; held until the next oGO.
- iDONE  in  1  1-cycle pulse: frame complete, iDATA valid.
- iDATA  in  12  conversion result, for the channel addressed in the previous frame.
- oRES_VLD  out  1  1-cycle pulse: result written.
- oRES_CH  out  3  channel of the written result.
- oRES_DATA  out  12  written result.
- iRD_CH  in  3  readback select.
- oRD_DATA  out  12  result[iRD_CH], combinational from the register file.
- oVALID  out  8  sticky per-channel valid flags.
- iCLR_VLD  in  1  clears oVALID; a same-cycle write still sets its bit.
- oERR  out  1  sticky timeout flag.

## Operation
- States: IDLE, ISSUE, WAIT, GAP.
- IDLE -> ISSUE when iEN=1 and either iMASK!=0 or iREQ=1.
- Channel selection in ISSUE:
  - If iREQ=1: oCH=iREQ_CH, pulse oREQ_ACK, and mark the tag as a request. The mask is not checked.
  - Otherwise: oCH is the first set bit of iMASK searching upward from rr_ptr+1, wrapping 7->0. rr_ptr is then set to oCH. Request frames leave rr_ptr unchanged.
  - iMASK and iREQ are sampled only in ISSUE.
- In ISSUE: pulse oGO and shift the tag pipeline (prev <= cur; cur <= {oCH, req flag, valid=1}); then -> WAIT.
- WAIT with iDONE=1 and prev.valid=1:
  - Write iDATA to result[prev.ch] and set oVALID[prev.ch].
  - Pulse oRES_VLD with oRES_CH/oRES_DATA.
  - Pulse oREQ_DONE if prev.req.
- WAIT with iDONE=1 and prev.valid=0: discard iDATA (stale channel).
- After iDONE: -> GAP if GAP_CYCLES>0, else directly to ISSUE/IDLE under the IDLE entry rules. iDONE outside WAIT is ignored.
- GAP: count GAP_CYCLES, then -> ISSUE if the IDLE entry condition holds, else -> IDLE. While iEN stays 1, tags survive through IDLE.
- iEN=0: the in-flight frame completes normally (result written if prev.valid), then -> IDLE with both tag valids cleared. The first frame after re-enable always discards.
- Simultaneous iREQ and a non-empty mask: the request wins; the scan resumes from rr_ptr on the next frame.

## Timing
- Reset values:
  - All outputs 0; oCH=0.
  - Tags invalid; rr_ptr=7, so the first scan picks the lowest set bit.
  - Result file 0; state IDLE.
- IDLE->ISSUE takes 1 cycle. oGO fires in the ISSUE cycle.
- oRES_* and oREQ_DONE are registered and assert the cycle after iDONE is sampled.
- A request's data arrives at the iDONE of the frame after its ISSUE. Latency oREQ_ACK -> oREQ_DONE is two frames plus one cycle.
- An asynchronous reset mid-frame returns everything to reset values immediately. Late iDONE is then ignored because the state is IDLE.

## Configuration
- ADC_SCHED_TIMEOUT_EN defined:
  - A WAIT counter runs. Reaching TIMEOUT_CYCLES without iDONE sets oERR, clears both tag valids, and goes to GAP.
  - oERR is cleared only by reset.
- Undefined: no counter; WAIT waits indefinitely; oERR is tied 0.

## Structure
- Package adc_sched_pkg:
  - NUM_CH=8, CH_W=3, DATA_W=12.
  - State encoding.
  - Tag struct {ch, req, valid}.
- Sub-module adc_rr_pick: combinational rotate-and-priority-find. Inputs are mask and pointer; outputs are next channel and a found flag.

## Test plan
- Mask 8'h05, GAP_CYCLES=0, ADC model returns 100×(previously addressed channel): oCH sequence 0,2,0,2. The first iDONE produces no oRES_VLD. Results then alternate ch0=0 and ch2=200. oVALID becomes 8'h05.
- Mask 8'h81: oCH sequence 0,7,0,7 (wrap check). result[7]=700.
- Mask 8'h01, iREQ with iREQ_CH=5 during WAIT: next ISSUE has oCH=5 and oREQ_ACK. One frame later, oRES_CH=5 with data 500 and oREQ_DONE, followed by a scan of ch0.
- iEN drops mid-WAIT: the frame completes and the state returns to IDLE. Re-enable with mask 8'h02: the first iDONE produces no oRES_VLD, the second writes ch1=100.
- Macro on, TIMEOUT_CYCLES=64, iDONE withheld: oERR=1 after 64 WAIT cycles. After that, the next completed frame is discarded.
- iRST pulsed low mid-WAIT: outputs, oVALID and result file read 0 immediately. A subsequent iDONE produces no oRES_VLD.

Source files
------------

// File: rtl/adc_sched_pkg.sv
// adc_sched_pkg
// Shared definitions for the ADC channel scheduler: channel/data widths,
// the scheduler state encoding and the one-frame channel tag carried between
// the frame that addresses a channel and the frame that returns its result.
package adc_sched_pkg;

    localparam int NUM_CH = 8;
    localparam int CH_W   = 3;
    localparam int DATA_W = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        GAP   = 2'd3
    } stateT;

    // Channel addressed by a frame, whether it came from a host request,
    // and whether the tag describes a real frame at all.
    typedef struct packed {
        logic [CH_W-1:0] ch;
        logic            req;
        logic            valid;
    } tagT;

endpackage

// File: rtl/adc_rr_pick.sv
// adc_rr_pick
// Combinational round-robin channel finder. Searches the mask upward starting
// one past the pointer, wrapping from the top channel back to channel 0; the
// pointer's own channel is the last candidate considered.
// Ports:
//   mask   in  NUM_CH  candidate channels
//   ptr    in  CH_W    channel chosen last time
//   nextCh out CH_W    first set channel after ptr (ptr when nothing is set)
//   found  out 1       at least one mask bit is set
module adc_rr_pick
    import adc_sched_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [CH_W-1:0]   ptr,
    output logic [CH_W-1:0]   nextCh,
    output logic              found
);

    // candCh[k] is the channel at search distance k+1 from ptr.
    logic [CH_W-1:0]   candCh [NUM_CH];
    logic [NUM_CH-1:0] candHit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : gCand
            assign candCh[gi]  = ptr + CH_W'(gi + 1);
            assign candHit[gi] = mask[candCh[gi]];
        end
    endgenerate

    // Walk from the farthest candidate down so the nearest hit wins.
    always_comb begin
        nextCh = ptr;
        found  = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (candHit[i]) begin
                nextCh = candCh[i];
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_scan_sched.sv
// adc_scan_sched
// Channel scheduler for the 8-channel serial ADC. Each frame addresses one
// channel: a pending host request wins, otherwise the next masked channel in
// round-robin order. The ADC returns the result of the previously addressed
// channel, so a two-entry tag pipeline (cur/prev) tracks which channel and
// which request each returned word belongs to.
// Optional feature: define ADC_SCHED_TIMEOUT_EN to enable the WAIT watchdog
// (oERR sticky until reset); without it oERR is constant 0.
// Ports:
//   iCLK, iRST           clock, asynchronous active-low reset
//   iEN, iMASK           enable and background scan mask
//   iREQ, iREQ_CH        one-shot request, held until oREQ_ACK
//   oREQ_ACK, oREQ_DONE  request issued / request result written (pulses)
//   oGO, oCH             frame start and channel to the serial engine
//   iDONE, iDATA         frame complete and previous channel's result
//   oRES_VLD/CH/DATA     result write strobe, channel and value
//   iRD_CH, oRD_DATA     combinational readback of the result file
//   oVALID, iCLR_VLD     sticky per-channel valid flags and their clear
//   oERR                 sticky WAIT timeout flag
module adc_scan_sched
    import adc_sched_pkg::*;
#(
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iEN,
    input  logic [NUM_CH-1:0] iMASK,
    input  logic              iREQ,
    input  logic [CH_W-1:0]   iREQ_CH,
    output logic              oREQ_ACK,
    output logic              oREQ_DONE,
    output logic              oGO,
    output logic [CH_W-1:0]   oCH,
    input  logic              iDONE,
    input  logic [DATA_W-1:0] iDATA,
    output logic              oRES_VLD,
    output logic [CH_W-1:0]   oRES_CH,
    output logic [DATA_W-1:0] oRES_DATA,
    input  logic [CH_W-1:0]   iRD_CH,
    output logic [DATA_W-1:0] oRD_DATA,
    output logic [NUM_CH-1:0] oVALID,
    input  logic              iCLR_VLD,
    output logic              oERR
);

    localparam logic [15:0] GAP_LAST = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;

    stateT             state;
    tagT               tagCur;
    tagT               tagPrev;
    logic [CH_W-1:0]   rrPtr;
    logic [CH_W-1:0]   chReg;
    logic [15:0]       gapCnt;
    logic [DATA_W-1:0] resFile [NUM_CH];

    logic [CH_W-1:0]   pickCh;
    logic              pickFound;
    logic              issueGo;
    logic [CH_W-1:0]   issueCh;
    logic              startCond;
    logic              resWrite;
    logic [NUM_CH-1:0] validNext;

    adc_rr_pick uPick (
        .mask   (iMASK),
        .ptr    (rrPtr),
        .nextCh (pickCh),
        .found  (pickFound)
    );

    // Selection happens in the ISSUE cycle itself from the live request and
    // mask; oGO/oREQ_ACK are decodes of that cycle and oCH is then held in
    // chReg until the next frame. If the mask emptied and no request is
    // pending, ISSUE falls back to IDLE without starting a frame.
    assign issueCh   = iREQ ? iREQ_CH : pickCh;
    assign issueGo   = (state == ISSUE) && (iREQ || pickFound);
    assign oGO       = issueGo;
    assign oREQ_ACK  = (state == ISSUE) && iREQ;
    assign oCH       = issueGo ? issueCh : chReg;

    assign startCond = iEN && ((iMASK != '0) || iREQ);
    assign resWrite  = (state == WAIT) && iDONE && tagPrev.valid;

    // A write in the same cycle as a clear still leaves its own bit set.
    assign validNext = (iCLR_VLD ? '0 : oVALID)
                     | (resWrite ? (NUM_CH'(1) << tagPrev.ch) : '0);

    assign oRD_DATA  = resFile[iRD_CH];

`ifdef ADC_SCHED_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] waitCnt;
`else
    // Timeout length has no effect when the watchdog is compiled out.
    logic unusedTimeout;
    assign unusedTimeout = |TIMEOUT_CYCLES;
    assign oERR = 1'b0;
`endif

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state     <= IDLE;
            tagCur    <= '0;
            tagPrev   <= '0;
            rrPtr     <= CH_W'(NUM_CH - 1);
            chReg     <= '0;
            gapCnt    <= '0;
            oRES_VLD  <= 1'b0;
            oRES_CH   <= '0;
            oRES_DATA <= '0;
            oREQ_DONE <= 1'b0;
            oVALID    <= '0;
`ifdef ADC_SCHED_TIMEOUT_EN
            waitCnt   <= '0;
            oERR      <= 1'b0;
`endif
        end else begin
            oRES_VLD  <= 1'b0;
            oREQ_DONE <= 1'b0;
            oVALID    <= validNext;
            if (resWrite) begin
                oRES_VLD  <= 1'b1;
                oRES_CH   <= tagPrev.ch;
                oRES_DATA <= iDATA;
                oREQ_DONE <= tagPrev.req;
            end

            case (state)
                IDLE: begin
                    // Tags survive IDLE only while the scheduler stays enabled.
                    if (!iEN) begin
                        tagCur.valid  <= 1'b0;
                        tagPrev.valid <= 1'b0;
                    end
                    if (startCond) state <= ISSUE;
                end

                ISSUE: begin
                    if (issueGo) begin
                        tagPrev <= tagCur;
                        tagCur  <= '{ch: issueCh, req: iREQ, valid: 1'b1};
                        chReg   <= issueCh;
                        if (!iREQ) rrPtr <= pickCh;
`ifdef ADC_SCHED_TIMEOUT_EN
                        waitCnt <= '0;
`endif
                        state   <= WAIT;
                    end else begin
                        state   <= IDLE;
                    end
                end

                WAIT: begin
                    if (iDONE) begin
                        if (!iEN) begin
                            tagCur.valid  <= 1'b0;
                            tagPrev.valid <= 1'b0;
                            state         <= IDLE;
                        end else if (GAP_CYCLES > 0) begin
                            gapCnt <= '0;
                            state  <= GAP;
                        end else begin
                            state  <= startCond ? ISSUE : IDLE;
                        end
                    end
`ifdef ADC_SCHED_TIMEOUT_EN
                    else if (waitCnt == TIMEOUT_LAST) begin
                        // The engine lost a frame: nothing in flight can be trusted.
                        oERR          <= 1'b1;
                        tagCur.valid  <= 1'b0;
                        tagPrev.valid <= 1'b0;
                        gapCnt        <= '0;
                        state         <= GAP;
                    end else begin
                        waitCnt <= waitCnt + 16'd1;
                    end
`endif
                end

                GAP: begin
                    if (!iEN) begin
                        tagCur.valid  <= 1'b0;
                        tagPrev.valid <= 1'b0;
                    end
                    if ((GAP_CYCLES == 0) || (gapCnt == GAP_LAST)) begin
                        state <= startCond ? ISSUE : IDLE;
                    end else begin
                        gapCnt <= gapCnt + 16'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            for (int i = 0; i < NUM_CH; i++) resFile[i] <= '0;
        end else if (resWrite) begin
            resFile[tagPrev.ch] <= iDATA;
        end
    end

endmodule
